// File: rtl/eth_pkg.sv
// Shared Ethernet constants, receive FSM states and byte-wide helpers
// used by the GMII MAC blocks.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [47:0] ETH_BCAST_MAC   = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] CRC32_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
    localparam int          ETH_MIN_PAYLOAD = 46;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DST_MAC,
        ST_SRC_MAC,
        ST_ETH_TYPE,
        ST_PAYLOAD,
        ST_DROP
    } rx_state_t;

    // Byte idx of a MAC address in wire order (0 = most significant byte).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            3'd5:    b = mac[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // One byte of reflected CRC-32, data consumed LSB first.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 accumulator: synchronous init to all-ones, update on en.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_nxt;

    // Next CRC value for the current input byte.
    always_comb begin
        crc_nxt = crc32_next(crc, data);
    end

    // Accumulator register; init takes priority over a byte update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 32'h0;
        end else if (init) begin
            crc <= 32'hFFFF_FFFF;
        end else if (en) begin
            crc <= crc_nxt;
        end
    end

endmodule

// File: rtl/gmii_rx_mac.sv
// GMII receive framer: strips preamble/SFD, filters destination MAC,
// captures source MAC and EtherType, streams payload without FCS and
// flags FCS/length errors on the last byte.
//
// Output stream: rx_valid is a one-cycle strobe with no ready; every
// cycle with rx_valid=1 carries one payload byte that the consumer must
// take. rx_sop/rx_eop/rx_err are meaningful only while rx_valid=1, and
// rx_err only together with rx_eop.
module gmii_rx_mac
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC   = 48'h00_11_22_33_44_55,
    parameter bit          CHECK_MAC   = 1'b1,
    parameter int          MAX_PAYLOAD = 1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic        rx_err,
    output logic [47:0] src_mac,
    output logic [15:0] eth_type
);

    // The payload counter includes the 4 FCS bytes, so limits are offset by 4.
    localparam logic [10:0] MIN_CNT = 11'(ETH_MIN_PAYLOAD + 4);
    localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD + 4);

    rx_state_t   state;
    logic        prev_dv;
    logic [2:0]  pre_cnt;
    logic [2:0]  fld_cnt;
    logic        match_board;
    logic        match_bcast;
    logic [47:0] src_shadow;
    logic [15:0] type_shadow;
    logic [7:0]  dly [5];
    logic [2:0]  dly_fill;
    logic        emitted;
    logic [10:0] pay_cnt;

    logic        crc_init;
    logic        crc_en;
    logic [31:0] crc;
    logic        board_hit;
    logic        bcast_hit;
    logic        frame_err;

    // CRC control, per-byte destination compare and end-of-frame verdict.
    always_comb begin
        crc_init  = 1'b0;
        crc_en    = 1'b0;
        board_hit = (gmii_rxd == mac_byte(BOARD_MAC, fld_cnt));
        bcast_hit = (gmii_rxd == mac_byte(ETH_BCAST_MAC, fld_cnt));
        frame_err = (crc != CRC32_RESIDUE) || (pay_cnt < MIN_CNT) || (pay_cnt > MAX_CNT);
        if (state == ST_PREAMBLE && gmii_rx_dv && gmii_rxd == ETH_SFD && pre_cnt >= 3'd6) begin
            crc_init = 1'b1;
        end
        if (gmii_rx_dv && (state == ST_DST_MAC || state == ST_SRC_MAC ||
                           state == ST_ETH_TYPE || state == ST_PAYLOAD)) begin
            crc_en = 1'b1;
        end
    end

    crc32_d8 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (crc_init),
        .en    (crc_en),
        .data  (gmii_rxd),
        .crc   (crc)
    );

    // Receive FSM with registered stream and header outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            // Treat dv as already high so a frame cut by reset cannot
            // fake a rising edge when reset releases mid-frame.
            prev_dv     <= 1'b1;
            pre_cnt     <= 3'd0;
            fld_cnt     <= 3'd0;
            match_board <= 1'b0;
            match_bcast <= 1'b0;
            src_shadow  <= 48'h0;
            type_shadow <= 16'h0;
            for (int i = 0; i < 5; i++) dly[i] <= 8'h00;
            dly_fill    <= 3'd0;
            emitted     <= 1'b0;
            pay_cnt     <= 11'd0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_sop      <= 1'b0;
            rx_eop      <= 1'b0;
            rx_err      <= 1'b0;
            src_mac     <= 48'h0;
            eth_type    <= 16'h0;
        end else begin
            prev_dv  <= gmii_rx_dv;
            rx_valid <= 1'b0;
            rx_sop   <= 1'b0;
            rx_eop   <= 1'b0;
            rx_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gmii_rx_dv && !prev_dv && gmii_rxd == ETH_PREAMBLE) begin
                        state   <= ST_PREAMBLE;
                        pre_cnt <= 3'd1;
                    end
                end
                ST_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state <= ST_IDLE;
                    end else if (gmii_rxd == ETH_PREAMBLE) begin
                        if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
                    end else if (gmii_rxd == ETH_SFD && pre_cnt >= 3'd6) begin
                        state       <= ST_DST_MAC;
                        fld_cnt     <= 3'd0;
                        match_board <= 1'b1;
                        match_bcast <= 1'b1;
                    end else begin
                        state <= ST_DROP;
                    end
                end
                ST_DST_MAC: begin
                    if (!gmii_rx_dv) begin
                        state <= ST_IDLE;
                    end else begin
                        match_board <= match_board && board_hit;
                        match_bcast <= match_bcast && bcast_hit;
                        if (fld_cnt == 3'd5) begin
                            fld_cnt <= 3'd0;
                            if (CHECK_MAC && !(match_board && board_hit) && !(match_bcast && bcast_hit)) begin
                                state <= ST_DROP;
                            end else begin
                                state <= ST_SRC_MAC;
                            end
                        end else begin
                            fld_cnt <= fld_cnt + 3'd1;
                        end
                    end
                end
                ST_SRC_MAC: begin
                    if (!gmii_rx_dv) begin
                        state <= ST_IDLE;
                    end else begin
                        src_shadow <= {src_shadow[39:0], gmii_rxd};
                        if (fld_cnt == 3'd5) begin
                            fld_cnt <= 3'd0;
                            state   <= ST_ETH_TYPE;
                        end else begin
                            fld_cnt <= fld_cnt + 3'd1;
                        end
                    end
                end
                ST_ETH_TYPE: begin
                    if (!gmii_rx_dv) begin
                        state <= ST_IDLE;
                    end else begin
                        type_shadow <= {type_shadow[7:0], gmii_rxd};
                        if (fld_cnt == 3'd1) begin
                            fld_cnt  <= 3'd0;
                            src_mac  <= src_shadow;
                            eth_type <= {type_shadow[7:0], gmii_rxd};
                            dly_fill <= 3'd0;
                            emitted  <= 1'b0;
                            pay_cnt  <= 11'd0;
                            state    <= ST_PAYLOAD;
                        end else begin
                            fld_cnt <= fld_cnt + 3'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (gmii_rx_dv) begin
                        // Five-byte delay hides the trailing FCS from the stream.
                        dly[0] <= gmii_rxd;
                        for (int i = 1; i < 5; i++) dly[i] <= dly[i-1];
                        if (pay_cnt != 11'h7FF) pay_cnt <= pay_cnt + 11'd1;
                        if (dly_fill == 3'd5) begin
                            rx_valid <= 1'b1;
                            rx_data  <= dly[4];
                            rx_sop   <= !emitted;
                            emitted  <= 1'b1;
                        end else begin
                            dly_fill <= dly_fill + 3'd1;
                        end
                    end else begin
                        if (emitted) begin
                            rx_valid <= 1'b1;
                            rx_data  <= dly[4];
                            rx_eop   <= 1'b1;
                            rx_err   <= frame_err;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!gmii_rx_dv) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_mac.sv
// Bench for gmii_rx_mac: builds complete GMII frames with their own FCS,
// queues the expected payload beats and checks the output stream.
module tb_gmii_rx_mac;

    localparam logic [47:0] BOARD = 48'h00_11_22_33_44_55;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sop;
    logic        rx_eop;
    logic        rx_err;
    logic [47:0] src_mac;
    logic [15:0] eth_type;

    int total = 0;
    int bad = 0;
    int beat_cnt = 0;
    bit mon_en = 1'b1;

    // {err, eop, sop, data} per expected payload beat
    logic [10:0] exp_q[$];
    logic [10:0] mon_exp;
    logic [7:0]  frm[$];

    gmii_rx_mac #(
        .BOARD_MAC   (BOARD),
        .CHECK_MAC   (1'b1),
        .MAX_PAYLOAD (1500)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rxd   (gmii_rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sop     (rx_sop),
        .rx_eop     (rx_eop),
        .rx_err     (rx_err),
        .src_mac    (src_mac),
        .eth_type   (eth_type)
    );

    // clock / watchdog
    always #4 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // scoreboard: every output beat is checked against the queue head
    always @(negedge clk) begin
        if (rx_valid) begin
            beat_cnt++;
            if (mon_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got data=%02h sop=%0b eop=%0b, required no beat",
                             rx_data, rx_sop, rx_eop);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({rx_eop, rx_sop, rx_data} !== mon_exp[9:0] ||
                        (rx_eop && rx_err !== mon_exp[10])) begin
                        bad++;
                        $display("FAIL beat: got eop=%0b sop=%0b data=%02h err=%0b, required eop=%0b sop=%0b data=%02h err=%0b",
                                 rx_eop, rx_sop, rx_data, rx_err,
                                 mon_exp[9], mon_exp[8], mon_exp[7:0], mon_exp[10]);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    // frame builder: npre x 0x55, SFD, header, incrementing payload, FCS;
    // flip >= 0 inverts bit 0 of that payload byte after the FCS is computed
    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                               input int len, input logic [7:0] base, input int flip, input int npre);
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  b;
        frm.delete();
        for (int i = 0; i < npre; i++) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            b = 8'(dst >> (40 - 8 * i)); frm.push_back(b); c = crc_byte(c, b);
        end
        for (int i = 0; i < 6; i++) begin
            b = 8'(src >> (40 - 8 * i)); frm.push_back(b); c = crc_byte(c, b);
        end
        b = typ[15:8]; frm.push_back(b); c = crc_byte(c, b);
        b = typ[7:0];  frm.push_back(b); c = crc_byte(c, b);
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i); frm.push_back(b); c = crc_byte(c, b);
        end
        fcs = ~c;
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
        if (flip >= 0) frm[npre + 15 + flip] = frm[npre + 15 + flip] ^ 8'h01;
    endtask

    // expected beats taken from the payload bytes actually placed on the wire
    task automatic expect_payload(input int len, input int npre, input bit err);
        logic [10:0] e;
        for (int i = 0; i < len; i++) begin
            e = {err && (i == len - 1), (i == len - 1), (i == 0), frm[npre + 15 + i]};
            exp_q.push_back(e);
        end
    endtask

    // driver tasks
    task automatic drive_frame(input int ifg);
        foreach (frm[i]) begin
            @(posedge clk); #1;
            gmii_rx_dv = 1'b1;
            gmii_rxd   = frm[i];
        end
        for (int i = 0; i < ifg; i++) begin
            @(posedge clk); #1;
            gmii_rx_dv = 1'b0;
            gmii_rxd   = 8'h00;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d beats still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        total++; if (rx_sop !== 1'b0) begin bad++; $display("FAIL reset_sop: got %b want 0", rx_sop); end
        total++; if (rx_eop !== 1'b0) begin bad++; $display("FAIL reset_eop: got %b want 0", rx_eop); end
        total++; if (rx_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", rx_err); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
        total++; if (src_mac !== 48'h0) begin bad++; $display("FAIL reset_src_mac: got %h want 0", src_mac); end
        total++; if (eth_type !== 16'h0) begin bad++; $display("FAIL reset_eth_type: got %h want 0", eth_type); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid: got %b want 0", rx_valid); end
    endtask

    task automatic test_unicast();
        int b0;
        logic [47:0] src;
        src = {16'h0A0B, 32'($urandom)};
        build_frame(BOARD, src, 16'h0800, 46, 8'h00, -1, 7);
        expect_payload(46, 7, 1'b0);
        b0 = beat_cnt;
        drive_frame(12);
        wait_drain("unicast");
        total++; if (beat_cnt - b0 != 46) begin bad++; $display("FAIL unicast_beats: got %0d want 46", beat_cnt - b0); end
        total++; if (eth_type !== 16'h0800) begin bad++; $display("FAIL unicast_eth_type: got %h want 0800", eth_type); end
        total++; if (src_mac !== src) begin bad++; $display("FAIL unicast_src_mac: got %h want %h", src_mac, src); end
    endtask

    task automatic test_bad_fcs();
        int b0;
        build_frame(BOARD, 48'h02_00_00_00_00_01, 16'h0800, 46, 8'h00, 10, 7);
        expect_payload(46, 7, 1'b1);
        b0 = beat_cnt;
        drive_frame(12);
        wait_drain("bad_fcs");
        total++; if (beat_cnt - b0 != 46) begin bad++; $display("FAIL bad_fcs_beats: got %0d want 46", beat_cnt - b0); end
    endtask

    task automatic test_dst_filter();
        int b0;
        logic [47:0] src;
        src = src_mac;
        build_frame(48'h00_11_22_33_44_56, 48'h02_AA_BB_CC_DD_EE, 16'h86DD, 50, 8'h10, -1, 7);
        b0 = beat_cnt;
        drive_frame(12);
        repeat (4) @(negedge clk);
        total++; if (beat_cnt - b0 != 0) begin bad++; $display("FAIL dst_reject_beats: got %0d want 0", beat_cnt - b0); end
        total++; if (src_mac !== src) begin bad++; $display("FAIL dst_reject_src_kept: got %h want %h", src_mac, src); end
        build_frame(BCAST, 48'h02_12_34_56_78_9A, 16'h0806, 48, 8'($urandom_range(0, 255)), -1, 7);
        expect_payload(48, 7, 1'b0);
        b0 = beat_cnt;
        drive_frame(12);
        wait_drain("bcast");
        total++; if (beat_cnt - b0 != 48) begin bad++; $display("FAIL bcast_beats: got %0d want 48", beat_cnt - b0); end
        total++; if (eth_type !== 16'h0806) begin bad++; $display("FAIL bcast_eth_type: got %h want 0806", eth_type); end
        total++; if (src_mac !== 48'h02_12_34_56_78_9A) begin bad++; $display("FAIL bcast_src_mac: got %h want 02123456789a", src_mac); end
    endtask

    task automatic test_length();
        int b0;
        int lens [3] = '{40, 1501, 1500};
        bit errs [3] = '{1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            build_frame(BOARD, 48'h02_00_00_00_00_40, 16'h0800, lens[t], 8'($urandom_range(0, 255)), -1, 7);
            expect_payload(lens[t], 7, errs[t]);
            b0 = beat_cnt;
            drive_frame(12);
            wait_drain("length");
            total++;
            if (beat_cnt - b0 != lens[t]) begin
                bad++; $display("FAIL length_beats: len=%0d got %0d beats want %0d", lens[t], beat_cnt - b0, lens[t]);
            end
        end
    endtask

    task automatic test_preamble();
        int b0;
        build_frame(BOARD, 48'h02_00_00_00_00_05, 16'h0800, 46, 8'h20, -1, 5);
        b0 = beat_cnt;
        drive_frame(12);
        repeat (4) @(negedge clk);
        total++; if (beat_cnt - b0 != 0) begin bad++; $display("FAIL short_preamble_beats: got %0d want 0", beat_cnt - b0); end
        build_frame(BOARD, 48'h02_00_00_00_00_54, 16'h0800, 46, 8'h30, -1, 7);
        frm[1] = 8'h54;
        b0 = beat_cnt;
        drive_frame(12);
        repeat (4) @(negedge clk);
        total++; if (beat_cnt - b0 != 0) begin bad++; $display("FAIL bad_preamble_beats: got %0d want 0", beat_cnt - b0); end
    endtask

    task automatic test_back_to_back();
        int b0;
        logic [47:0] src2;
        src2 = {16'h02FE, 32'($urandom)};
        b0 = beat_cnt;
        build_frame(BOARD, 48'h02_00_00_00_0B_01, 16'h0800, 46, 8'($urandom_range(0, 255)), -1, 7);
        expect_payload(46, 7, 1'b0);
        drive_frame(1);
        build_frame(BCAST, src2, 16'h88CC, 52, 8'($urandom_range(0, 255)), -1, 7);
        expect_payload(52, 7, 1'b0);
        drive_frame(12);
        wait_drain("back_to_back");
        total++; if (beat_cnt - b0 != 98) begin bad++; $display("FAIL b2b_beats: got %0d want 98", beat_cnt - b0); end
        total++; if (src_mac !== src2) begin bad++; $display("FAIL b2b_src_mac: got %h want %h", src_mac, src2); end
        total++; if (eth_type !== 16'h88CC) begin bad++; $display("FAIL b2b_eth_type: got %h want 88cc", eth_type); end
    endtask

    task automatic test_reset_mid();
        int b0;
        int cut;
        b0 = 0;
        build_frame(BOARD, 48'h02_77_66_55_44_33, 16'h0800, 60, 8'($urandom_range(0, 255)), -1, 7);
        cut = 8 + 14 + 20;
        mon_en = 1'b0;
        for (int i = 0; i < frm.size(); i++) begin
            @(posedge clk); #1;
            gmii_rx_dv = 1'b1;
            gmii_rxd   = frm[i];
            if (i == cut) begin
                rst_n = 1'b0;
                #1;
                total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", rx_valid); end
                total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h want 00", rx_data); end
                total++; if (src_mac !== 48'h0) begin bad++; $display("FAIL midrst_src_mac: got %h want 0", src_mac); end
                total++; if (eth_type !== 16'h0) begin bad++; $display("FAIL midrst_eth_type: got %h want 0", eth_type); end
            end
            if (i == cut + 2) begin
                rst_n = 1'b1;
                b0 = beat_cnt;
            end
        end
        @(posedge clk); #1;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (12) @(negedge clk);
        total++; if (beat_cnt - b0 != 0) begin bad++; $display("FAIL midrst_tail_beats: got %0d want 0", beat_cnt - b0); end
        mon_en = 1'b1;
        build_frame(BOARD, 48'h02_44_44_44_44_44, 16'h0800, 47, 8'($urandom_range(0, 255)), -1, 7);
        expect_payload(47, 7, 1'b0);
        b0 = beat_cnt;
        drive_frame(12);
        wait_drain("after_reset");
        total++; if (beat_cnt - b0 != 47) begin bad++; $display("FAIL after_reset_beats: got %0d want 47", beat_cnt - b0); end
        total++; if (src_mac !== 48'h02_44_44_44_44_44) begin bad++; $display("FAIL after_reset_src_mac: got %h want 024444444444", src_mac); end
    endtask

    // sequence and report
    initial begin
        test_reset();
        test_unicast();
        test_bad_fcs();
        test_dst_filter();
        test_length();
        test_preamble();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
